// File: rtl/pll_ctrl_pkg.sv
// Shared types, widths and rPLL divider-code helpers for the dynamic mode controller.
package pll_ctrl_pkg;

  localparam int unsigned DSEL_W = 6;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAIL
  } pll_state_e;

  // Gowin rPLL dynamic select inputs take the complement-style code 64 - divider.
  function automatic logic [DSEL_W-1:0] idsel_code(input int unsigned idiv);
    return DSEL_W'(64 - idiv);
  endfunction

  function automatic logic [DSEL_W-1:0] fbdsel_code(input int unsigned fbdiv);
    return DSEL_W'(64 - fbdiv);
  endfunction

  // ODSEL is encoded on half the output divider value.
  function automatic logic [DSEL_W-1:0] odsel_code(input int unsigned odiv);
    return DSEL_W'(64 - (odiv / 2));
  endfunction

endpackage

// File: rtl/pll_dyn_mode_ctrl_if.sv
// Mode-change request handshake between a requester and the PLL mode controller.
interface pll_dyn_mode_ctrl_if #(
  parameter int unsigned MODE_W = 2
);
  logic              req_valid;
  logic [MODE_W-1:0] req_mode;
  logic              req_ready;

  modport master (output req_valid, output req_mode, input req_ready);
  modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_dyn_mode_ctrl.sv
// Run-time rPLL mode controller: programs divider selects, sequences PLL reset,
// qualifies lock and releases downstream reset domains in order.
module pll_dyn_mode_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned NUM_DOM      = 3,
  parameter int unsigned DEFAULT_MODE = 0,
  parameter logic [DSEL_W*NUM_MODES-1:0] MODE_IDSEL  = {6'd63, 6'd63, 6'd62, 6'd63},
  parameter logic [DSEL_W*NUM_MODES-1:0] MODE_FBDSEL = {6'd27, 6'd9,  6'd10, 6'd53},
  parameter logic [DSEL_W*NUM_MODES-1:0] MODE_ODSEL  = {6'd62, 6'd63, 6'd60, 6'd62},
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned REL_GAP      = 8,
  localparam int unsigned MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_lock,
  pll_dyn_mode_ctrl_if.slave   req_if,
  output logic                 pll_reset,
  output logic [DSEL_W-1:0]    pll_idsel,
  output logic [DSEL_W-1:0]    pll_fbdsel,
  output logic [DSEL_W-1:0]    pll_odsel,
  output logic [NUM_DOM-1:0]   dom_rst,
  output logic                 locked,
  output logic [MODE_W-1:0]    cur_mode,
  output logic                 fail
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > REL_GAP) ? RST_CYCLES : REL_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned REL_W   = $clog2(NUM_DOM + 1);

  pll_state_e          state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [STAB_W-1:0]   stab_q, stab_n;
  logic [TMO_W-1:0]    tmo_q, tmo_n;
  logic [RTY_W-1:0]    retry_q, retry_n;
  logic [REL_W-1:0]    rel_q, rel_n;
  logic [MODE_W-1:0]   mode_n;
  logic [NUM_DOM-1:0]  dom_n;
  logic                pll_reset_n, locked_n, ready_q, ready_n, fail_n;
  logic                lock_s, req_acc, mode_ok;

  logic [DSEL_W-1:0]   id_tab [NUM_MODES];
  logic [DSEL_W-1:0]   fb_tab [NUM_MODES];
  logic [DSEL_W-1:0]   od_tab [NUM_MODES];

  // Unpack the flat mode tables into indexable arrays.
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_tab
    assign id_tab[m] = MODE_IDSEL[DSEL_W*m +: DSEL_W];
    assign fb_tab[m] = MODE_FBDSEL[DSEL_W*m +: DSEL_W];
    assign od_tab[m] = MODE_ODSEL[DSEL_W*m +: DSEL_W];
  end

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign req_if.req_ready = ready_q;

  // Next-state, counter and output decode.
  always_comb begin
    state_n = state_q;
    cnt_n   = '0;
    stab_n  = '0;
    tmo_n   = '0;
    retry_n = retry_q;
    rel_n   = rel_q;
    mode_n  = cur_mode;
    dom_n   = dom_rst;
    fail_n  = fail;
    req_acc = ready_q && req_if.req_valid;
    mode_ok = (32'(req_if.req_mode) < NUM_MODES);

    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_n = WAIT_LOCK;
        else                                 cnt_n   = cnt_q + CNT_W'(1);
      end
      WAIT_LOCK: begin
        stab_n = lock_s ? stab_q + STAB_W'(1) : '0;
        tmo_n  = tmo_q + TMO_W'(1);
        // Lock qualification takes priority over a coincident timeout.
        if (lock_s && (stab_q == STAB_W'(LOCK_STABLE - 1))) begin
          state_n = RELEASE;
          rel_n   = '0;
          dom_n   = '1;
          dom_n[0] = 1'b0;
        end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_n = retry_q + RTY_W'(1);
            state_n = RESET_PLL;
          end else begin
            state_n = FAIL;
            fail_n  = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_n = RESET_PLL;
          retry_n = '0;
        end else if (rel_q == REL_W'(NUM_DOM - 1)) begin
          state_n = RUN;
          retry_n = '0;
        end else if (cnt_q == CNT_W'(REL_GAP - 1)) begin
          rel_n = rel_q + REL_W'(1);
          dom_n = dom_rst & ~(NUM_DOM'(1) << rel_n);
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (req_acc && mode_ok) begin
          state_n = RESET_PLL;
          mode_n  = req_if.req_mode;
          fail_n  = 1'b0;
          retry_n = '0;
        end else if (!lock_s) begin
          state_n = RESET_PLL;
          retry_n = '0;
        end
      end
      FAIL: begin
        if (req_acc && mode_ok) begin
          state_n = RESET_PLL;
          mode_n  = req_if.req_mode;
          fail_n  = 1'b0;
          retry_n = '0;
        end
      end
      default: state_n = RESET_PLL;
    endcase

    if ((state_n != RELEASE) && (state_n != RUN)) dom_n = '1;
    pll_reset_n = (state_n == RESET_PLL) || (state_n == FAIL);
    locked_n    = (state_n == RELEASE) || (state_n == RUN);
    ready_n     = (state_n == RUN) || (state_n == FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      stab_q     <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      rel_q      <= '0;
      cur_mode   <= MODE_W'(DEFAULT_MODE);
      pll_idsel  <= id_tab[MODE_W'(DEFAULT_MODE)];
      pll_fbdsel <= fb_tab[MODE_W'(DEFAULT_MODE)];
      pll_odsel  <= od_tab[MODE_W'(DEFAULT_MODE)];
      pll_reset  <= 1'b1;
      dom_rst    <= '1;
      locked     <= 1'b0;
      ready_q    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      stab_q     <= stab_n;
      tmo_q      <= tmo_n;
      retry_q    <= retry_n;
      rel_q      <= rel_n;
      cur_mode   <= mode_n;
      pll_idsel  <= id_tab[mode_n];
      pll_fbdsel <= fb_tab[mode_n];
      pll_odsel  <= od_tab[mode_n];
      pll_reset  <= pll_reset_n;
      dom_rst    <= dom_n;
      locked     <= locked_n;
      ready_q    <= ready_n;
      fail       <= fail_n;
    end
  end

endmodule

// File: tb/tb_pll_dyn_mode_ctrl.sv
// Randomised scoreboard bench for pll_dyn_mode_ctrl with a timeline-level reference model.
module tb_pll_dyn_mode_ctrl;
  import pll_ctrl_pkg::*;

  localparam int unsigned NUM_MODES    = 3;
  localparam int unsigned NUM_DOM      = 3;
  localparam int unsigned DEFAULT_MODE = 1;
  localparam int unsigned RST_CYCLES   = 4;
  localparam int unsigned LOCK_STABLE  = 16;
  localparam int unsigned LOCK_TIMEOUT = 64;
  localparam int unsigned MAX_RETRY    = 1;
  localparam int unsigned REL_GAP      = 4;
  localparam int unsigned MODE_W       = 2;

  localparam int unsigned IDIV_T  [NUM_MODES] = '{1, 3, 4};
  localparam int unsigned FBDIV_T [NUM_MODES] = '{11, 55, 37};
  localparam int unsigned ODIV_T  [NUM_MODES] = '{4, 2, 8};

  localparam logic [6*NUM_MODES-1:0] TB_ID = {idsel_code(4),  idsel_code(3),  idsel_code(1)};
  localparam logic [6*NUM_MODES-1:0] TB_FB = {fbdsel_code(37), fbdsel_code(55), fbdsel_code(11)};
  localparam logic [6*NUM_MODES-1:0] TB_OD = {odsel_code(8),  odsel_code(2),  odsel_code(4)};

  typedef struct packed {
    logic               pll_reset;
    logic [5:0]         idsel;
    logic [5:0]         fbdsel;
    logic [5:0]         odsel;
    logic [NUM_DOM-1:0] dom_rst;
    logic               locked;
    logic [MODE_W-1:0]  cur_mode;
    logic               fail;
    logic               ready;
  } obs_t;

  logic clk = 1'b0;
  logic reset, pll_lock;
  logic pll_reset, locked, fail;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [NUM_DOM-1:0] dom_rst;
  logic [MODE_W-1:0] cur_mode;

  pll_dyn_mode_ctrl_if #(.MODE_W(MODE_W)) req_if ();

  pll_dyn_mode_ctrl #(
    .NUM_MODES(NUM_MODES), .NUM_DOM(NUM_DOM), .DEFAULT_MODE(DEFAULT_MODE),
    .MODE_IDSEL(TB_ID), .MODE_FBDSEL(TB_FB), .MODE_ODSEL(TB_OD),
    .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .REL_GAP(REL_GAP)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .req_if(req_if),
    .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .dom_rst(dom_rst), .locked(locked), .cur_mode(cur_mode), .fail(fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  obs_t exp_q[$];

  // Reference model: phase plus time-in-phase, lock seen two samples late.
  localparam int P_RST = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3, P_FAIL = 4;
  int ph, t, run_len, retry, mode;
  bit fl;
  logic lk_old, lk_older;

  function automatic obs_t model_out();
    obs_t o;
    o.pll_reset = (ph == P_RST) || (ph == P_FAIL);
    o.idsel     = 6'(64 - IDIV_T[mode]);
    o.fbdsel    = 6'(64 - FBDIV_T[mode]);
    o.odsel     = 6'(64 - ODIV_T[mode] / 2);
    for (int k = 0; k < NUM_DOM; k++)
      o.dom_rst[k] = (ph == P_RUN) ? 1'b0 : (ph == P_REL) ? (t < k * int'(REL_GAP)) : 1'b1;
    o.locked    = (ph == P_REL) || (ph == P_RUN);
    o.cur_mode  = MODE_W'(mode);
    o.fail      = fl;
    o.ready     = (ph == P_RUN) || (ph == P_FAIL);
    return o;
  endfunction

  task automatic model_step(input logic rst, input logic lk, input logic v, input int m);
    logic ls;
    bit acc;
    if (rst) begin
      ph = P_RST; t = 0; run_len = 0; retry = 0; mode = DEFAULT_MODE; fl = 0;
      lk_old = 0; lk_older = 0;
      return;
    end
    ls = lk_older;
    lk_older = lk_old;
    lk_old = lk;
    acc = ((ph == P_RUN) || (ph == P_FAIL)) && v && (m < NUM_MODES);
    if (acc) begin
      mode = m; fl = 0; ph = P_RST; t = 0; retry = 0;
    end else begin
      case (ph)
        P_RST: if (t + 1 >= RST_CYCLES) begin ph = P_WAIT; t = 0; run_len = 0; end else t++;
        P_WAIT: begin
          run_len = ls ? run_len + 1 : 0;
          if (run_len >= LOCK_STABLE) begin ph = P_REL; t = 0; end
          else if (t + 1 >= LOCK_TIMEOUT) begin
            if (retry < MAX_RETRY) begin retry++; ph = P_RST; t = 0; end
            else begin ph = P_FAIL; fl = 1; end
          end else t++;
        end
        P_REL: begin
          if (!ls) begin ph = P_RST; t = 0; retry = 0; end
          else if (t >= (NUM_DOM - 1) * REL_GAP) begin ph = P_RUN; retry = 0; end
          else t++;
        end
        P_RUN: if (!ls) begin ph = P_RST; t = 0; retry = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic rst, input logic lk, input logic v, input logic [MODE_W-1:0] m);
    reset = rst;
    pll_lock = lk;
    req_if.req_valid = v;
    req_if.req_mode = m;
    @(posedge clk);
    model_step(rst, lk, v, int'(m));
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(input int n, input logic lk);
    for (int i = 0; i < n; i++) cycle(1'b0, lk, 1'b0, '0);
  endtask

  task automatic request(input int m, input logic lk);
    cycle(1'b0, lk, 1'b1, MODE_W'(m));
  endtask

  // Monitor: outputs are presented every cycle; compare against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{pll_reset: pll_reset, idsel: pll_idsel, fbdsel: pll_fbdsel, odsel: pll_odsel,
            dom_rst: dom_rst, locked: locked, cur_mode: cur_mode, fail: fail, ready: req_if.req_ready};
      cyc++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle %0d outputs: got rst=%b id=%0d fb=%0d od=%0d dom=%b lk=%b mode=%0d fail=%b rdy=%b, want rst=%b id=%0d fb=%0d od=%0d dom=%b lk=%b mode=%0d fail=%b rdy=%b",
                 cyc, a.pll_reset, a.idsel, a.fbdsel, a.odsel, a.dom_rst, a.locked, a.cur_mode, a.fail, a.ready,
                 e.pll_reset, e.idsel, e.fbdsel, e.odsel, e.dom_rst, e.locked, e.cur_mode, e.fail, e.ready);
      end
    end
  end

  initial begin
    logic lk;
    // Power-up: lock rises a while after the PLL reset pulse.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle(14, 1'b0);
    idle(60, 1'b1);
    // Directed mode change to entry 2 with a realistic lock drop.
    request(2, 1'b1);
    idle(8, 1'b0);
    idle(60, 1'b1);
    // Random requests including the out-of-range index.
    for (int i = 0; i < 6; i++) begin
      request(int'($urandom_range(0, 3)), 1'b1);
      idle(int'($urandom_range(0, 12)), 1'b0);
      idle(60, 1'b1);
    end
    // Glitchy lock: never stable long enough, retry then fail.
    request(0, 1'b1);
    for (int i = 0; i < 150; i++) cycle(1'b0, (i % 10) != 9, 1'b0, '0);
    request(3, 1'b0);
    idle(5, 1'b0);
    request(1, 1'b0);
    idle(6, 1'b0);
    idle(60, 1'b1);
    // No lock at all.
    request(2, 1'b1);
    idle(150, 1'b0);
    request(0, 1'b0);
    idle(60, 1'b1);
    // Single-cycle lock loss in RUN.
    idle(1, 1'b0);
    idle(60, 1'b1);
    // Reset asserted in the middle of the release sequence.
    request(1, 1'b1);
    idle(25, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    idle(60, 1'b1);
    // Random soak.
    lk = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      cycle(($urandom_range(0, 499) == 0), lk, ($urandom_range(0, 29) == 0), MODE_W'($urandom_range(0, 3)));
    end
    idle(3, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
